// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Access size encoding, FSM states and the default base address live here.
package mem_arb_pkg;

   localparam logic [31:0] MEM_ARB_BASE_ADDR = 32'h0100_0000;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'd0,
      SIZE_HALF    = 2'd1,
      SIZE_WORD    = 2'd2,
      SIZE_ILLEGAL = 2'd3
   } size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

   // True when the size code is illegal or the address is not naturally aligned.
   function automatic logic size_misaligned(input size_e size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE:    bad = 1'b0;
         SIZE_HALF:    bad = lo[0];
         SIZE_WORD:    bad = (lo != 2'b00);
         default:      bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data port: extends loaded sub-words and
// merges sub-word store data into a previously read memory word.
module lsu_align
   import mem_arb_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH-1:0] rd_word,
   input  logic [1:0]        offset,
   input  size_e             size,
   input  logic              is_unsigned,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] load_data,
   output logic [DWIDTH-1:0] merged_data
);

   logic [4:0]        lane_shift;
   logic [DWIDTH-1:0] shifted;
   logic [DWIDTH-1:0] lane_mask;

   assign lane_shift = {offset, 3'b000};
   assign shifted    = rd_word >> lane_shift;

   // Byte lanes follow the low address bits on both the load and store path.
   always_comb begin
      load_data = shifted;
      lane_mask = '1;
      case (size)
         SIZE_BYTE: begin
            load_data = {{(DWIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            lane_mask = DWIDTH'(8'hFF) << lane_shift;
         end
         SIZE_HALF: begin
            load_data = {{(DWIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            lane_mask = DWIDTH'(16'hFFFF) << lane_shift;
         end
         default: begin
            load_data = rd_word;
            lane_mask = '1;
         end
      endcase
   end

   assign merged_data = (rd_word & ~lane_mask) | ((wdata << lane_shift) & lane_mask);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port
// and a data port; sub-word stores are done as read-modify-write.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(MEM_ARB_BASE_ADDR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [AWIDTH-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic [DWIDTH-1:0] if_rdata_o,
   output logic              if_rvalid_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [1:0]        d_size_i,
   input  logic              d_unsigned_i,
   input  logic [AWIDTH-1:0] d_addr_i,
   input  logic [DWIDTH-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic [DWIDTH-1:0] d_rdata_o,
   output logic              d_rvalid_o,
   output logic              d_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [DWIDTH-1:0] mem_data_i,
   output logic              busy_o
);

   // Handshake: a requester holds req and payload until it sees gnt; gnt is a
   // combinational one-cycle pulse issued only in IDLE. Responses (rvalid) are
   // one-cycle pulses with no back-pressure; rdata holds between responses.

   state_e            state;
   logic              last_d;
   logic [AWIDTH-1:0] rmw_addr;
   logic [DWIDTH-1:0] rmw_data;
   size_e             d_size;
   logic              d_bad;
   logic              if_bad;
   logic              d_word_store;
   logic              pick_d;
   logic              grant_ok;
   logic [DWIDTH-1:0] load_data;
   logic [DWIDTH-1:0] merged_data;

   assign d_size       = size_e'(d_size_i);
   assign d_bad        = (d_addr_i < BASE_ADDR) || size_misaligned(d_size, d_addr_i[1:0]);
   assign if_bad       = (if_addr_i < BASE_ADDR) || (if_addr_i[1:0] != 2'b00);
   assign d_word_store = d_we_i && (d_size == SIZE_WORD);

   // last_d low means fetch was served last, so data wins a tie next.
   assign grant_ok = (state == IDLE) && !rst;
   assign pick_d   = d_req_i && (!if_req_i || !last_d);
   assign d_gnt_o  = grant_ok && pick_d;
   assign if_gnt_o = grant_ok && if_req_i && !pick_d;
   assign busy_o   = (state != IDLE);

   lsu_align #(
      .DWIDTH(DWIDTH)
   ) u_lsu_align (
      .rd_word     (mem_data_i),
      .offset      (d_addr_i[1:0]),
      .size        (d_size),
      .is_unsigned (d_unsigned_i),
      .wdata       (d_wdata_i),
      .load_data   (load_data),
      .merged_data (merged_data)
   );

   always_comb begin
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_addr_o     = BASE_ADDR;
      mem_data_o     = '0;
      if (state == RMW_WR) begin
         // A reset landing on the write cycle cancels the write.
         if (!rst) begin
            mem_write_en_o = 1'b1;
            mem_addr_o     = rmw_addr;
            mem_data_o     = rmw_data;
         end
      end else if (if_gnt_o && !if_bad) begin
         mem_read_en_o = 1'b1;
         mem_addr_o    = if_addr_i;
      end else if (d_gnt_o && !d_bad) begin
         mem_addr_o = d_addr_i;
         if (d_word_store) begin
            mem_write_en_o = 1'b1;
            mem_data_o     = d_wdata_i;
         end else begin
            mem_read_en_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_d      <= 1'b0;
         if_rvalid_o <= 1'b0;
         if_rdata_o  <= '0;
         d_rvalid_o  <= 1'b0;
         d_err_o     <= 1'b0;
         d_rdata_o   <= '0;
         rmw_addr    <= BASE_ADDR;
         rmw_data    <= '0;
      end else begin
         if_rvalid_o <= if_gnt_o;
         d_rvalid_o  <= 1'b0;
         d_err_o     <= 1'b0;
         if (if_gnt_o) begin
            last_d     <= 1'b0;
            if_rdata_o <= if_bad ? '0 : mem_data_i;
         end
         if (d_gnt_o) begin
            last_d <= 1'b1;
            if (d_bad) begin
               d_rvalid_o <= 1'b1;
               d_err_o    <= 1'b1;
               d_rdata_o  <= '0;
            end else if (!d_we_i) begin
               d_rvalid_o <= 1'b1;
               d_rdata_o  <= load_data;
            end else if (d_word_store) begin
               d_rvalid_o <= 1'b1;
            end else begin
               // Merge against the word read this cycle; written back next cycle.
               state    <= RMW_WR;
               rmw_addr <= d_addr_i;
               rmw_data <= merged_data;
            end
         end
         if (state == RMW_WR) begin
            state      <= IDLE;
            d_rvalid_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a word memory model
// and a behavioural reference of arbitration, alignment and store merging.
module tb_mem_arbiter;

   localparam int          AW        = 32;
   localparam int          DW        = 32;
   localparam logic [31:0] BASE      = 32'h0100_0000;
   localparam int          MEM_WORDS = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic [DW-1:0] if_rdata_o;
   logic          if_rvalid_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [1:0]    d_size_i;
   logic          d_unsigned_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_gnt_o;
   logic [DW-1:0] d_rdata_o;
   logic          d_rvalid_o;
   logic          d_err_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
   logic          mem_read_en_o;
   logic          mem_write_en_o;
   logic [DW-1:0] mem_data_i;
   logic          busy_o;

   always #5 clk = ~clk;

   mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
      .d_unsigned_i(d_unsigned_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o),
      .d_err_o(d_err_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
      .mem_data_i(mem_data_i), .busy_o(busy_o)
   );

   // Memory environment: combinational read, write on the rising edge.
   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_data = 32'h0;

   function automatic logic [5:0] widx(input logic [31:0] a);
      return 6'((a - BASE) >> 2);
   endfunction

   function automatic logic in_mem(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * MEM_WORDS));
   endfunction

   assign mem_data_i = in_mem(mem_addr_o) ? mem[widx(mem_addr_o)] : 32'h0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (mem_write_en_o && in_mem(mem_addr_o)) mem[widx(mem_addr_o)] <= mem_data_o;
   end

   // Reference model state
   int          n_assert = 0;
   int          n_fail   = 0;
   bit          rr_last_d = 1'b0;
   logic [31:0] exp_d_rdata  = 32'h0;
   logic [31:0] exp_if_rdata = 32'h0;

   function automatic bit data_bad(input logic [31:0] a, input logic [1:0] sz);
      return (a < BASE) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input bit uns);
      int     off;
      longint v;
      off = int'(a[1:0]);
      if (sz == 2'd2) return w;
      if (sz == 2'd0) begin
         v = longint'((w >> (8 * off)) & 32'hFF);
         if (!uns && v >= 128) v = v - 256;
      end else begin
         v = longint'((w >> (8 * off)) & 32'hFFFF);
         if (!uns && v >= 32768) v = v - 65536;
      end
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic [31:0] wd);
      logic [7:0] b [4];
      int         off;
      off = int'(a[1:0]);
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      b[off] = wd[7:0];
      if (sz == 2'd1 && off < 3) b[off+1] = wd[15:8];
      return {b[3], b[2], b[1], b[0]};
   endfunction

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int i, input logic [31:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_data = v;
      ref_mem[i] = v;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic clear_reqs();
      if_req_i = 1'b0; d_req_i = 1'b0;
   endtask

   // One transaction from request to response, predicted by the model.
   task automatic run_txn(input bit rf, input logic [31:0] fa, input bit rd, input bit we,
                          input logic [1:0] sz, input bit uns, input logic [31:0] da,
                          input logic [31:0] wd, input string tag);
      bit          pick_d, bad, sub;
      logic [31:0] old_w, new_w;
      @(negedge clk);
      if_req_i = rf; if_addr_i = fa;
      d_req_i = rd; d_we_i = we; d_size_i = sz; d_unsigned_i = uns;
      d_addr_i = da; d_wdata_i = wd;
      #1;
      pick_d = rd && (!rf || !rr_last_d);
      check1({tag, ":d_gnt"}, d_gnt_o, pick_d);
      check1({tag, ":if_gnt"}, if_gnt_o, rf && !pick_d);
      check1({tag, ":rvalid_quiet"}, if_rvalid_o | d_rvalid_o, 1'b0);
      check1({tag, ":en_excl"}, mem_read_en_o & mem_write_en_o, 1'b0);
      if (pick_d) begin
         rr_last_d = 1'b1;
         bad = data_bad(da, sz);
         sub = !bad && we && (sz != 2'd2);
         old_w = in_mem(da) ? ref_mem[widx(da)] : 32'h0;
         if (bad) begin
            check1({tag, ":err_no_rd"}, mem_read_en_o, 1'b0);
            check1({tag, ":err_no_wr"}, mem_write_en_o, 1'b0);
         end else begin
            check32({tag, ":d_mem_addr"}, mem_addr_o, da);
            check1({tag, ":d_wr_en"}, mem_write_en_o, we && sz == 2'd2);
            check1({tag, ":d_rd_en"}, mem_read_en_o, !(we && sz == 2'd2));
            if (we && sz == 2'd2) check32({tag, ":d_wr_data"}, mem_data_o, wd);
         end
         @(negedge clk);
         clear_reqs();
         if (sub) begin
            if_req_i = 1'b1; if_addr_i = BASE;
            #1;
            new_w = model_merge(old_w, da, sz, wd);
            check1({tag, ":rmw_busy"}, busy_o, 1'b1);
            check1({tag, ":rmw_no_gnt"}, if_gnt_o | d_gnt_o, 1'b0);
            check1({tag, ":rmw_no_ack"}, d_rvalid_o, 1'b0);
            check1({tag, ":rmw_wr_en"}, mem_write_en_o, 1'b1);
            check32({tag, ":rmw_addr"}, mem_addr_o, da);
            check32({tag, ":rmw_data"}, mem_data_o, new_w);
            ref_mem[widx(da)] = new_w;
            @(negedge clk);
            clear_reqs();
         end else if (!bad && we) begin
            ref_mem[widx(da)] = wd;
         end
         #1;
         if (bad) exp_d_rdata = 32'h0;
         else if (!we) exp_d_rdata = model_load(old_w, da, sz, uns);
         check1({tag, ":d_rvalid"}, d_rvalid_o, 1'b1);
         check1({tag, ":d_err"}, d_err_o, bad);
         check32({tag, ":d_rdata"}, d_rdata_o, exp_d_rdata);
         check1({tag, ":d_busy_after"}, busy_o, 1'b0);
      end else if (rf) begin
         rr_last_d = 1'b0;
         bad = (fa < BASE) || (fa[1:0] != 2'b00);
         check1({tag, ":if_rd_en"}, mem_read_en_o, !bad);
         if (!bad) check32({tag, ":if_mem_addr"}, mem_addr_o, fa);
         @(negedge clk);
         clear_reqs();
         #1;
         exp_if_rdata = bad ? 32'h0 : ref_mem[widx(fa)];
         check1({tag, ":if_rvalid"}, if_rvalid_o, 1'b1);
         check32({tag, ":if_rdata"}, if_rdata_o, exp_if_rdata);
         check1({tag, ":if_no_d_rvalid"}, d_rvalid_o, 1'b0);
      end else begin
         check1({tag, ":idle_en"}, mem_read_en_o | mem_write_en_o, 1'b0);
         check32({tag, ":idle_addr"}, mem_addr_o, BASE);
         check32({tag, ":idle_data"}, mem_data_o, 32'h0);
      end
   endtask

   initial begin
      bit          rf, rdq, we, uns;
      int          sel;
      logic [1:0]  sz;
      logic [31:0] fa, da, wd;

      rst = 1'b1;
      if_req_i = 1'b1; if_addr_i = BASE;
      d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_unsigned_i = 1'b0;
      d_addr_i = BASE; d_wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check1("rst:gnt", if_gnt_o | d_gnt_o, 1'b0);
      check1("rst:rvalid", if_rvalid_o | d_rvalid_o, 1'b0);
      check1("rst:err", d_err_o, 1'b0);
      check32("rst:if_rdata", if_rdata_o, 32'h0);
      check32("rst:d_rdata", d_rdata_o, 32'h0);
      check1("rst:en", mem_read_en_o | mem_write_en_o, 1'b0);
      check32("rst:mem_addr", mem_addr_o, BASE);
      check32("rst:mem_data", mem_data_o, 32'h0);
      check1("rst:busy", busy_o, 1'b0);
      clear_reqs();
      for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom());
      @(negedge clk);
      rst = 1'b0;

      // Both ports held for three cycles: data, fetch, data.
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = BASE + 32'd4;
      d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_unsigned_i = 1'b0; d_addr_i = BASE;
      #1;
      check1("rr1:d_gnt", d_gnt_o, 1'b1);
      check1("rr1:if_gnt", if_gnt_o, 1'b0);
      @(negedge clk); #1;
      check1("rr2:d_gnt", d_gnt_o, 1'b0);
      check1("rr2:if_gnt", if_gnt_o, 1'b1);
      check1("rr2:d_rvalid", d_rvalid_o, 1'b1);
      check32("rr2:d_rdata", d_rdata_o, ref_mem[0]);
      @(negedge clk); #1;
      check1("rr3:d_gnt", d_gnt_o, 1'b1);
      check1("rr3:if_gnt", if_gnt_o, 1'b0);
      check1("rr3:if_rvalid", if_rvalid_o, 1'b1);
      check32("rr3:if_rdata", if_rdata_o, ref_mem[1]);
      check1("rr3:d_rvalid", d_rvalid_o, 1'b0);
      @(negedge clk);
      clear_reqs();
      #1;
      check1("rr4:d_rvalid", d_rvalid_o, 1'b1);
      check1("rr4:if_rvalid", if_rvalid_o, 1'b0);
      rr_last_d = 1'b1; exp_d_rdata = ref_mem[0]; exp_if_rdata = ref_mem[1];

      preload(0, 32'hDEAD_BEEF);
      run_txn(1, BASE, 0, 0, 2'd0, 0, BASE, 32'h0, "fetch_base");
      check32("fetch_deadbeef", if_rdata_o, 32'hDEAD_BEEF);

      preload(0, 32'h1122_3344);
      run_txn(0, BASE, 1, 1, 2'd0, 0, BASE + 32'd1, 32'h0000_00AB, "sb_lane1");
      check32("sb_mem_word", mem[0], 32'h1122_AB44);
      run_txn(0, BASE, 1, 0, 2'd2, 0, BASE, 32'h0, "lw_after_sb");
      check32("lw_merged", d_rdata_o, 32'h1122_AB44);

      preload(1, 32'h8000_0080);
      run_txn(0, BASE, 1, 0, 2'd0, 0, BASE + 32'd4, 32'h0, "lb_signed");
      check32("lb_signed_val", d_rdata_o, 32'hFFFF_FF80);
      run_txn(0, BASE, 1, 0, 2'd0, 1, BASE + 32'd4, 32'h0, "lbu");
      check32("lbu_val", d_rdata_o, 32'h0000_0080);
      run_txn(0, BASE, 1, 0, 2'd1, 0, BASE + 32'd6, 32'h0, "lh_signed");
      check32("lh_signed_val", d_rdata_o, 32'hFFFF_8000);

      run_txn(0, BASE, 1, 1, 2'd1, 0, BASE + 32'd3, 32'h1234, "sh_misaligned");
      run_txn(0, BASE, 1, 0, 2'd2, 0, BASE - 32'd4, 32'h0, "lw_below_base");
      run_txn(0, BASE, 1, 0, 2'd3, 0, BASE + 32'd8, 32'h0, "size_illegal");
      run_txn(0, BASE, 1, 1, 2'd2, 0, BASE + 32'd10, 32'h0, "sw_misaligned");
      run_txn(1, BASE + 32'd2, 0, 0, 2'd0, 0, BASE, 32'h0, "fetch_misaligned");
      run_txn(1, BASE - 32'd8, 0, 0, 2'd0, 0, BASE, 32'h0, "fetch_below_base");
      run_txn(0, BASE, 0, 0, 2'd0, 0, BASE, 32'h0, "no_request");
      run_txn(0, BASE, 1, 1, 2'd1, 0, BASE + 32'd12, 32'hCAFE, "sh_ok");

      for (int k = 0; k < 150; k++) begin
         sel = int'($urandom_range(0, 2));
         rf  = (sel != 1);
         rdq = (sel != 0);
         fa = BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1));
         if ($urandom_range(0, 9) == 0) fa = fa + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 19) == 0) fa = BASE - 32'd4;
         da = BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1));
         if ($urandom_range(0, 15) == 0) da = BASE - 32'($urandom_range(1, 16));
         sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (sz == 2'd1 && $urandom_range(0, 3) != 0) da[0] = 1'b0;
         if (sz == 2'd2 && $urandom_range(0, 3) != 0) da[1:0] = 2'b00;
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         wd  = $urandom();
         run_txn(rf, fa, rdq, we, sz, uns, da, wd, $sformatf("rnd%0d", k));
      end

      // Reset arriving in the write-back cycle of a byte store.
      preload(2, 32'h7766_5544);
      @(negedge clk);
      d_req_i = 1'b1; d_we_i = 1'b1; d_size_i = 2'd0; d_unsigned_i = 1'b0;
      d_addr_i = BASE + 32'd9; d_wdata_i = 32'h5A;
      #1;
      check1("rstrmw:d_gnt", d_gnt_o, 1'b1);
      @(negedge clk);
      clear_reqs();
      rst = 1'b1;
      #1;
      check1("rstrmw:busy", busy_o, 1'b1);
      check1("rstrmw:no_wr", mem_write_en_o, 1'b0);
      @(negedge clk); #1;
      check1("rstrmw:no_ack", d_rvalid_o, 1'b0);
      check1("rstrmw:idle", busy_o, 1'b0);
      check32("rstrmw:mem_kept", mem[2], ref_mem[2]);
      check32("rstrmw:d_rdata", d_rdata_o, 32'h0);
      rst = 1'b0;
      rr_last_d = 1'b0; exp_d_rdata = 32'h0; exp_if_rdata = 32'h0;
      run_txn(0, BASE, 1, 0, 2'd2, 0, BASE + 32'd8, 32'h0, "lw_after_rst");
      check32("lw_after_rst_val", d_rdata_o, 32'h7766_5544);
      run_txn(1, BASE + 32'd8, 1, 0, 2'd2, 0, BASE, 32'h0, "rr_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
